// File: rtl/inst_cache_sa.sv
// Two-way set-associative instruction cache with zero-latency hit path and a
// single outstanding line fill; flushes during a fill discard the returning line.
module inst_cache_sa #(
  parameter int ADDR_WIDTH  = 17,
  parameter int INST_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 2,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rdy,
  input  logic                                  flush,
  input  logic                                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0]                 fetch_addr,
  output logic                                  fetch_hit,
  output logic [INST_WIDTH-1:0]                 fetch_data,
  output logic                                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0]                 mem_req_addr,
  input  logic                                  mem_resp_valid,
  input  logic [(INST_WIDTH<<BLOCK_WIDTH)-1:0]  mem_resp_data,
  output logic                                  mem_resp_ready
);

  localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - BLOCK_WIDTH;
  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int LINE_WIDTH = INST_WIDTH << BLOCK_WIDTH;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                  state_q;
  logic                    mem_req_valid_q;
  logic [ADDR_WIDTH-1:0]   mem_req_addr_q;
  logic                    discard_q;
  logic [INDEX_WIDTH-1:0]  fill_idx_q;
  logic [TAG_WIDTH-1:0]    fill_tag_q;
  logic [1:0][SETS-1:0]    valid_q;
  logic [SETS-1:0]         lru_q;

  logic [BLOCK_WIDTH-1:0]  f_off;
  logic [INDEX_WIDTH-1:0]  f_idx;
  logic [TAG_WIDTH-1:0]    f_tag;
  logic [1:0]              way_match;
  logic [LINE_WIDTH-1:0]   way_line [2];
  logic [LINE_WIDTH-1:0]   sel_line;
  logic                    hit_any;
  logic                    victim;
  logic                    install;
  logic [1:0]              fill_we;

  assign f_off = fetch_addr[BLOCK_WIDTH-1:0];
  assign f_idx = fetch_addr[BLOCK_WIDTH +: INDEX_WIDTH];
  assign f_tag = fetch_addr[ADDR_WIDTH-1 -: TAG_WIDTH];

  // Victim selection prefers an empty way before consulting the LRU bit.
  assign victim  = !valid_q[0][fill_idx_q] ? 1'b0 :
                   !valid_q[1][fill_idx_q] ? 1'b1 : lru_q[fill_idx_q];
  assign install = !rst && rdy && !flush && (state_q == ST_WAIT) &&
                   mem_resp_valid && !discard_q;
  assign fill_we = {install && victim, install && !victim};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      logic [TAG_WIDTH-1:0]  tag_mem  [SETS];
      logic [LINE_WIDTH-1:0] line_mem [SETS];

      // Asynchronous read keeps the hit path at zero cycles of latency.
      assign way_match[gi] = valid_q[gi][f_idx] && (tag_mem[f_idx] == f_tag);
      assign way_line[gi]  = line_mem[f_idx];

      always_ff @(posedge clk) begin
        if (fill_we[gi]) begin
          tag_mem[fill_idx_q]  <= fill_tag_q;
          line_mem[fill_idx_q] <= mem_resp_data;
        end
      end
    end
  endgenerate

  assign hit_any        = |way_match;
  assign sel_line       = way_match[1] ? way_line[1] : way_line[0];
  assign fetch_data     = sel_line[INST_WIDTH*int'(f_off) +: INST_WIDTH];
  assign fetch_hit      = fetch_valid && !flush && (state_q == ST_IDLE) && hit_any;
  assign mem_resp_ready = rdy && (state_q == ST_WAIT);
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = mem_req_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      discard_q       <= 1'b0;
      fill_idx_q      <= '0;
      fill_tag_q      <= '0;
      valid_q         <= '0;
      lru_q           <= '0;
    end else if (rdy) begin
      if (flush) begin
        valid_q <= '0;
        lru_q   <= '0;
        if (state_q == ST_WAIT) begin
          if (mem_resp_valid) begin
            state_q         <= ST_IDLE;
            mem_req_valid_q <= 1'b0;
            discard_q       <= 1'b0;
          end else begin
            discard_q <= 1'b1;
          end
        end
      end else if (state_q == ST_IDLE) begin
        if (fetch_valid) begin
          if (hit_any) begin
            lru_q[f_idx] <= ~way_match[1];
          end else begin
            fill_idx_q      <= f_idx;
            fill_tag_q      <= f_tag;
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= {f_tag, f_idx, {BLOCK_WIDTH{1'b0}}};
            state_q         <= ST_WAIT;
          end
        end
      end else if (mem_resp_valid) begin
        mem_req_valid_q <= 1'b0;
        discard_q       <= 1'b0;
        state_q         <= ST_IDLE;
        if (!discard_q) begin
          valid_q[victim][fill_idx_q] <= 1'b1;
          lru_q[fill_idx_q]           <= ~victim;
        end
      end
    end
  end

endmodule
